// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB full-speed receive control path:
// FSM state encoding, PID codes, SYNC pattern and PID validation.
package usb_rx_pkg;

    localparam int CNT_W = 7;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SYNC_WAIT = 4'd1;
    localparam logic [3:0] S_CHK_SYNC  = 4'd2;
    localparam logic [3:0] S_PID_WAIT  = 4'd3;
    localparam logic [3:0] S_CHK_PID   = 4'd4;
    localparam logic [3:0] S_DATA_WAIT = 4'd5;
    localparam logic [3:0] S_STORE     = 4'd6;
    localparam logic [3:0] S_HS_EOP    = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_ERR       = 4'd9;
    localparam logic [3:0] S_EIDLE     = 4'd10;

    // Enum values are pinned to the fixed encodings above so the state
    // register stays stable across tool versions and netlist probes.
    typedef enum logic [3:0] {
        ST_IDLE      = S_IDLE,
        ST_SYNC_WAIT = S_SYNC_WAIT,
        ST_CHK_SYNC  = S_CHK_SYNC,
        ST_PID_WAIT  = S_PID_WAIT,
        ST_CHK_PID   = S_CHK_PID,
        ST_DATA_WAIT = S_DATA_WAIT,
        ST_STORE     = S_STORE,
        ST_HS_EOP    = S_HS_EOP,
        ST_DONE      = S_DONE,
        ST_ERR       = S_ERR,
        ST_EIDLE     = S_EIDLE
    } rx_state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    function automatic logic pid_valid(input logic [7:0] pid_byte);
        logic code_ok;
        case (pid_byte[3:0])
            PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK: code_ok = 1'b1;
            default:                                                 code_ok = 1'b0;
        endcase
        return code_ok && (pid_byte[7:4] == ~pid_byte[3:0]);
    endfunction

endpackage

// File: rtl/rx_byte_counter.sv
// Counts bytes stored after the PID; clears on command and saturates at MAX_BYTES.
module rx_byte_counter
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 66
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != MAX_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_CNT);

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive control FSM: checks SYNC and PID, gates payload bytes into the
// RX FIFO, enforces packet length and reports done / sticky error.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 66   // must not exceed 127 (7-bit count)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             shift_enable,
    input  logic             eop,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic             rx_done,
    output logic [3:0]       rx_pid,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    rx_state_t        state_q, state_d;
    logic             w_enable_q, w_enable_d;
    logic             rx_done_q, rx_done_d;
    logic [3:0]       rx_pid_q, rx_pid_d;

    logic             eopq;
    logic             cnt_clear, cnt_enable, cnt_at_max;
    logic [CNT_W-1:0] cnt;
    logic             is_token, len_ok;

    assign eopq     = eop & shift_enable;
    assign is_token = (rx_pid_q == PID_OUT) || (rx_pid_q == PID_IN);
    assign len_ok   = is_token ? (cnt == CNT_W'(2))
                               : ((cnt >= CNT_W'(2)) && (cnt <= MAX_CNT));

    rx_byte_counter #(
        .MAX_BYTES (MAX_BYTES)
    ) u_byte_counter (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (cnt),
        .at_max (cnt_at_max)
    );

    always_comb begin
        state_d    = state_q;
        rx_pid_d   = rx_pid_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_edge) state_d = ST_SYNC_WAIT;
            end
            ST_SYNC_WAIT: begin
                if (eopq)               state_d = ST_ERR;
                else if (byte_received) state_d = ST_CHK_SYNC;
            end
            ST_CHK_SYNC: begin
                state_d = (rcv_data == SYNC_BYTE) ? ST_PID_WAIT : ST_ERR;
            end
            ST_PID_WAIT: begin
                if (eopq)               state_d = ST_ERR;
                else if (byte_received) state_d = ST_CHK_PID;
            end
            ST_CHK_PID: begin
                if (pid_valid(rcv_data)) begin
                    rx_pid_d  = rcv_data[3:0];
                    cnt_clear = 1'b1;
                    if ((rcv_data[3:0] == PID_ACK) || (rcv_data[3:0] == PID_NAK)) begin
                        state_d = ST_HS_EOP;
                    end else begin
                        state_d = ST_DATA_WAIT;
                    end
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA_WAIT: begin
                // EOP takes priority: a byte arriving alongside it is dropped
                if (eopq)               state_d = len_ok ? ST_DONE : ST_EIDLE;
                else if (byte_received) state_d = ST_STORE;
            end
            ST_STORE: begin
                if (cnt_at_max) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_enable = 1'b1;
                    state_d    = ST_DATA_WAIT;
                end
            end
            ST_HS_EOP: begin
                if (eopq)               state_d = ST_DONE;
                else if (byte_received) state_d = ST_ERR;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (eopq) state_d = ST_EIDLE;
            end
            ST_EIDLE: begin
                if (d_edge) state_d = ST_SYNC_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered off the current state, so each appears one
    // cycle after STORE / DONE is entered and never depends on an input.
    always_comb begin
        w_enable_d = (state_q == ST_STORE) && !cnt_at_max;
        rx_done_d  = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            w_enable_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_pid_q   <= 4'h0;
        end else begin
            state_q    <= state_d;
            w_enable_q <= w_enable_d;
            rx_done_q  <= rx_done_d;
            rx_pid_q   <= rx_pid_d;
        end
    end

    assign rcving   = (state_q == ST_SYNC_WAIT) || (state_q == ST_CHK_SYNC) ||
                      (state_q == ST_PID_WAIT)  || (state_q == ST_CHK_PID)  ||
                      (state_q == ST_DATA_WAIT) || (state_q == ST_STORE)    ||
                      (state_q == ST_HS_EOP)    || (state_q == ST_ERR);
    assign r_error  = (state_q == ST_ERR) || (state_q == ST_EIDLE);
    assign w_enable = w_enable_q;
    assign rx_done  = rx_done_q;
    assign rx_pid   = rx_pid_q;
    assign byte_cnt = cnt;

endmodule
